ft_error_monitor: RTL and testbench

//  Collects error_detected flags from the fault-tolerant 2:1/3:1 datapath muxes. Classifies faults
//  per source as transient or permanent; keeps saturating error statistics; raises an acked irq.

---
 rtl/ft_pkg.sv | 17 +
 rtl/ft_err_src_tracker.sv | 49 ++++
 rtl/ft_error_monitor.sv | 143 ++++++++++++++
 tb/tb_ft_error_monitor.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// ----------------------------------------------------------------------------
// ft_pkg
// Shared definitions for the fault-tolerant mux error monitor.
// Holds the 2-bit fault state encodings that appear on the monitor's
// fault_state output and are consumed by the BIST/trap controller.
// Ports: none (package).
// ----------------------------------------------------------------------------
package ft_pkg;

  // Fault classification; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FS_OK        = 2'b00,
    FS_TRANSIENT = 2'b01,
    FS_PERMANENT = 2'b10
  } fault_state_t;

endpackage

// File: rtl/ft_err_src_tracker.sv
// ----------------------------------------------------------------------------
// ft_err_src_tracker
// Per-source fault tracker. Counts consecutive flagged cycles of one mux
// error_detected line and latches a sticky "permanent" bit once the run
// length reaches PERM_THRESH.
// Ports:
//   clk         in  rising-edge clock
//   i_clr       in  synchronous clear (reset or soft clear), discards history
//   i_err       in  error_detected flag of this source
//   o_perm      out sticky permanent-fault bit (registered)
//   o_perm_rise out combinational: o_perm will be set at the coming edge
// ----------------------------------------------------------------------------
module ft_err_src_tracker #(
  parameter int PERM_THRESH = 4
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_err,
  output logic o_perm,
  output logic o_perm_rise
);

  localparam int HIT_W = $clog2(PERM_THRESH + 1);

  logic [HIT_W-1:0] r_hit_cnt;
  logic             r_perm;
  logic             w_reach;

  // The run reaches the threshold on this edge when the counter already
  // holds PERM_THRESH-1 and the source is flagged again.
  assign w_reach     = i_err && (r_hit_cnt == HIT_W'(PERM_THRESH - 1));
  assign o_perm_rise = w_reach && !r_perm && !i_clr;
  assign o_perm      = r_perm;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_hit_cnt <= '0;
      r_perm    <= 1'b0;
    end else begin
      if (!i_err)
        r_hit_cnt <= '0;
      else if (r_hit_cnt != HIT_W'(PERM_THRESH))
        r_hit_cnt <= r_hit_cnt + HIT_W'(1);
      if (w_reach)
        r_perm <= 1'b1;
    end
  end

endmodule

// File: rtl/ft_error_monitor.sv
// ----------------------------------------------------------------------------
// ft_error_monitor
// Collects error_detected flags from the fault-tolerant mux bank, classifies
// faults as transient or permanent, keeps a saturating count of flagged
// cycles and raises a level interrupt held until acknowledged.
// Ports:
//   clk         in  rising-edge clock
//   rst         in  synchronous active-high reset
//   err_in      in  [NUM_SRC] error_detected flags, bit i = mux i
//   clear       in  synchronous soft clear, same effect as rst
//   irq_ack     in  acknowledge pending irq
//   irq         out event interrupt, held until ack
//   fault_state out [2] 00 OK, 01 TRANSIENT, 10 PERMANENT
//   perm_mask   out [NUM_SRC] sticky per-source permanent-fault bits
//   err_count   out [CNT_W] flagged cycles, saturating at all-ones
//   last_src    out lowest flagged index of the most recent flagged cycle
// ----------------------------------------------------------------------------
module ft_error_monitor
  import ft_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int CNT_W       = 8,
  parameter int PERM_THRESH = 4,
  parameter int QUIET_WIN   = 16,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int QUIET_W    = $clog2(QUIET_WIN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] err_in,
  input  logic               clear,
  input  logic               irq_ack,
  output logic               irq,
  output logic [1:0]         fault_state,
  output logic [NUM_SRC-1:0] perm_mask,
  output logic [CNT_W-1:0]   err_count,
  output logic [SRC_W-1:0]   last_src
);

  logic               w_clr;
  logic               w_any_err;
  logic               w_new_perm;
  logic               w_set_irq;
  logic [NUM_SRC-1:0] w_perm_rise;
  logic [SRC_W-1:0]   w_low_idx;

  fault_state_t       r_state;
  logic [QUIET_W-1:0] r_quiet_cnt;
  logic               r_irq;
  logic [CNT_W-1:0]   r_err_count;
  logic [SRC_W-1:0]   r_last_src;

  assign w_clr      = rst | clear;
  assign w_any_err  = |err_in;
  assign w_new_perm = |w_perm_rise;

  // A new permanent bit always raises irq (entry into PERMANENT or a further
  // bit while already there); otherwise only the OK->TRANSIENT entry does.
  assign w_set_irq  = w_new_perm || ((r_state == FS_OK) && w_any_err);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    ft_err_src_tracker #(
      .PERM_THRESH (PERM_THRESH)
    ) u_tracker (
      .clk         (clk),
      .i_clr       (w_clr),
      .i_err       (err_in[g]),
      .o_perm      (perm_mask[g]),
      .o_perm_rise (w_perm_rise[g])
    );
  end

  // Lowest set index wins: scan from the top so lower indices overwrite.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (err_in[i])
        w_low_idx = SRC_W'(i);
    end
  end

  // Statistics: saturating flagged-cycle count and last flagged source.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_err_count <= '0;
      r_last_src  <= '0;
    end else if (w_any_err) begin
      if (r_err_count != '1)
        r_err_count <= r_err_count + CNT_W'(1);
      r_last_src <= w_low_idx;
    end
  end

  // Fault classification FSM with the quiet-window counter and irq.
  // A set event and an ack on the same edge leave irq asserted.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state     <= FS_OK;
      r_quiet_cnt <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_set_irq)
        r_irq <= 1'b1;
      else if (irq_ack)
        r_irq <= 1'b0;

      case (r_state)
        FS_OK: begin
          if (w_new_perm) begin
            r_state <= FS_PERMANENT;
          end else if (w_any_err) begin
            r_state     <= FS_TRANSIENT;
            r_quiet_cnt <= '0;
          end
        end
        FS_TRANSIENT: begin
          if (w_new_perm) begin
            r_state <= FS_PERMANENT;
          end else if (w_any_err) begin
            r_quiet_cnt <= '0;
          end else if (r_quiet_cnt == QUIET_W'(QUIET_WIN - 1)) begin
            r_state     <= FS_OK;
            r_quiet_cnt <= '0;
          end else begin
            r_quiet_cnt <= r_quiet_cnt + QUIET_W'(1);
          end
        end
        FS_PERMANENT: begin
          r_state <= FS_PERMANENT;
        end
        default: begin
          r_state <= FS_OK;
        end
      endcase
    end
  end

  assign irq         = r_irq;
  assign fault_state = r_state;
  assign err_count   = r_err_count;
  assign last_src    = r_last_src;

endmodule

// File: tb/tb_ft_error_monitor.sv
// ----------------------------------------------------------------------------
// tb_ft_error_monitor
// Directed self-checking bench for ft_error_monitor with default parameters
// (8 sources, 8-bit count, threshold 4, quiet window 16).
// ----------------------------------------------------------------------------
module tb_ft_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_in;
  logic       clear;
  logic       irq_ack;
  logic       irq;
  logic [1:0] fault_state;
  logic [7:0] perm_mask;
  logic [7:0] err_count;
  logic [2:0] last_src;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  ft_error_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .err_in      (err_in),
    .clear       (clear),
    .irq_ack     (irq_ack),
    .irq         (irq),
    .fault_state (fault_state),
    .perm_mask   (perm_mask),
    .err_count   (err_count),
    .last_src    (last_src)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic [7:0] e, input logic c, input logic a, input logic r);
    err_in  = e;
    clear   = c;
    irq_ack = a;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against one expected snapshot.
  task automatic checkAll(input string tag, input logic i, input logic [1:0] fs,
                          input logic [7:0] pm, input logic [7:0] cnt, input logic [2:0] ls);
    checkOutput({tag, ".irq"},         32'(irq),         32'(i));
    checkOutput({tag, ".fault_state"}, 32'(fault_state), 32'(fs));
    checkOutput({tag, ".perm_mask"},   32'(perm_mask),   32'(pm));
    checkOutput({tag, ".err_count"},   32'(err_count),   32'(cnt));
    checkOutput({tag, ".last_src"},    32'(last_src),    32'(ls));
  endtask

  initial begin
    err_in  = '0;
    clear   = 1'b0;
    irq_ack = 1'b0;
    rst     = 1'b1;

    // Reset for three cycles with no errors.
    for (int k = 0; k < 3; k++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkAll("reset", 1'b0, 2'b00, 8'h00, 8'd0, 3'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkAll("idle", 1'b0, 2'b00, 8'h00, 8'd0, 3'd0);

    // Single flagged cycle on source 2 -> TRANSIENT with irq.
    applyStimulus(8'h04, 1'b0, 1'b0, 1'b0);
    checkAll("trans_entry", 1'b1, 2'b01, 8'h00, 8'd1, 3'd2);
    // Ack is quiet cycle 1.
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("ack_clears_irq", 32'(irq), 32'd0);
    // Quiet cycles 2..15 keep TRANSIENT.
    for (int k = 2; k <= 15; k++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("quiet15_still_trans", 32'(fault_state), 32'd1);
    // 16th quiet cycle returns to OK without raising irq.
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkAll("quiet16_ok", 1'b0, 2'b00, 8'h00, 8'd1, 3'd2);

    // Re-entry into TRANSIENT raises irq again.
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b0);
    checkAll("reentry", 1'b1, 2'b01, 8'h00, 8'd2, 3'd7);

    // Run of 3 on source 0, then a gap (with ack): no permanent bit.
    for (int k = 0; k < 3; k++) applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkAll("run3_gap", 1'b0, 2'b01, 8'h00, 8'd5, 3'd0);

    // Run of 4 on source 0 -> permanent on the 4th edge.
    for (int k = 0; k < 3; k++) applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkAll("run3_no_perm", 1'b0, 2'b01, 8'h00, 8'd8, 3'd0);
    applyStimulus(8'h01, 1'b0, 1'b0, 1'b0);
    checkAll("perm_entry", 1'b1, 2'b10, 8'h01, 8'd9, 3'd0);

    // Lowest set index of 0x12 is 1.
    applyStimulus(8'h12, 1'b0, 1'b0, 1'b0);
    checkAll("prio_enc", 1'b1, 2'b10, 8'h01, 8'd10, 3'd1);

    // Source 5 for 4 cycles, ack coincident with the new perm bit.
    for (int k = 0; k < 3; k++) applyStimulus(8'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h20, 1'b0, 1'b1, 1'b0);
    checkAll("ack_vs_set", 1'b1, 2'b10, 8'h21, 8'd14, 3'd5);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("ack_in_perm", 32'(irq), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    checkAll("ack_idle", 1'b0, 2'b10, 8'h21, 8'd14, 3'd5);

    // Saturation of err_count: 14 + 240 = 254, +1 = 255, then holds.
    for (int k = 0; k < 240; k++) applyStimulus(8'h40, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_254", 32'(err_count), 32'd254);
    applyStimulus(8'h40, 1'b0, 1'b0, 1'b0);
    checkOutput("cnt_255", 32'(err_count), 32'd255);
    for (int k = 0; k < 59; k++) applyStimulus(8'h40, 1'b0, 1'b0, 1'b0);
    checkAll("cnt_sat", 1'b1, 2'b10, 8'h61, 8'd255, 3'd6);

    // Soft clear in PERMANENT with all sources flagged and ack asserted.
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    checkAll("clear", 1'b0, 2'b00, 8'h00, 8'd0, 3'd0);

    // Source 6 history was discarded: 3 flagged cycles do not make it permanent.
    for (int k = 0; k < 3; k++) applyStimulus(8'h40, 1'b0, 1'b0, 1'b0);
    checkAll("post_clear", 1'b1, 2'b01, 8'h00, 8'd3, 3'd6);

    // Seven quiet cycles (quiet_cnt = 7), then reset with errors flagged.
    for (int k = 0; k < 7; k++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("quiet7_trans", 32'(fault_state), 32'd1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
    checkAll("rst_mid_trans", 1'b0, 2'b00, 8'h00, 8'd0, 3'd0);

    // Fresh operation after reset.
    applyStimulus(8'h08, 1'b0, 1'b0, 1'b0);
    checkAll("post_rst", 1'b1, 2'b01, 8'h00, 8'd1, 3'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
